// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one Memory_Interface port between instruction fetch (I) and load/store (D).
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed D-over-I priority for round-robin under contention.
module memory_arbiter #(
  parameter int LATENCY      = 2,
  parameter int ADDRESS_SIZE = 32,
  parameter int WORD         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDRESS_SIZE-1:0] i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [WORD-1:0]         i_rdata,
  output logic                    i_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDRESS_SIZE-1:0] d_addr,
  input  logic [WORD-1:0]         d_wdata,
  input  logic [1:0]              d_size,
  input  logic                    d_ext,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [WORD-1:0]         d_rdata,
  output logic                    d_err,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [WORD-1:0]         mem_wdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [1:0]              mem_size,
  output logic                    mem_ext,
  input  logic [WORD-1:0]         mem_rdata,
  input  logic                    mem_exc
);

  typedef struct packed {
    logic valid;
    logic owner;
    logic isRead;
    logic ext;
    logic err;
  } tag_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  tag_t                    r_stage [1:LATENCY];
  logic [ADDRESS_SIZE-1:0] r_lastAddr;
  tag_t                    w_resp;
  tag_t                    w_issue;
  logic                    w_hazard;
  logic                    w_dElig;
  logic                    w_iElig;
  logic                    w_dGnt;
  logic                    w_iGnt;
  logic                    w_dMis;
  logic                    w_iMis;
  logic [WORD-1:0]         w_retData;

  // A store may not share the cycle in which a load's data is returning.
  assign w_resp   = r_stage[LATENCY];
  assign w_hazard = w_resp.valid & w_resp.isRead;
  assign w_dElig  = ~rst & d_req & ~(d_we & w_hazard);
  assign w_iElig  = ~rst & i_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_prioD;

  assign w_dGnt = w_dElig & (~w_iElig | r_prioD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prioD <= 1'b1;
    end else if (w_dElig & w_iElig) begin
      r_prioD <= ~w_dGnt;
    end
  end
`else
  assign w_dGnt = w_dElig;
`endif

  assign w_iGnt = w_iElig & ~w_dGnt;

  assign w_dMis = d_size[1] ? (d_addr[1:0] != 2'b00) : (d_size[0] & d_addr[0]);
  assign w_iMis = (i_addr[1:0] != 2'b00);

  always_comb begin
    w_issue = '0;
    if (w_dGnt) begin
      w_issue.valid  = 1'b1;
      w_issue.owner  = OWNER_D;
      w_issue.isRead = ~d_we;
      w_issue.ext    = d_ext;
      w_issue.err    = w_dMis;
    end else if (w_iGnt) begin
      w_issue.valid  = 1'b1;
      w_issue.owner  = OWNER_I;
      w_issue.isRead = 1'b1;
      w_issue.ext    = 1'b1;
      w_issue.err    = w_iMis;
    end
  end

  assign i_gnt     = w_iGnt;
  assign d_gnt     = w_dGnt;
  assign mem_en    = (w_dGnt & ~w_dMis) | (w_iGnt & ~w_iMis);
  assign mem_we    = w_dGnt & d_we & ~w_dMis;
  assign mem_addr  = w_dGnt ? d_addr : (w_iGnt ? i_addr : r_lastAddr);
  assign mem_wdata = (w_dGnt & d_we) ? d_wdata : '0;
  assign mem_size  = w_dGnt ? d_size : (w_iGnt ? 2'd2 : 2'd0);
  // A returning load's extension mode overrides the one for the newly granted request.
  assign mem_ext   = w_resp.valid ? w_resp.ext : (w_dGnt ? d_ext : w_iGnt);

  assign w_retData = (w_resp.isRead & ~w_resp.err) ? mem_rdata : '0;
  assign i_rvalid  = w_resp.valid & (w_resp.owner == OWNER_I);
  assign d_rvalid  = w_resp.valid & (w_resp.owner == OWNER_D);
  assign i_rdata   = i_rvalid ? w_retData : '0;
  assign d_rdata   = d_rvalid ? w_retData : '0;
  assign i_err     = i_rvalid & w_resp.err;
  assign d_err     = d_rvalid & (w_resp.err | (mem_exc & ~w_resp.isRead));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= LATENCY; k++) begin
        r_stage[k] <= '0;
      end
      r_lastAddr <= '0;
    end else begin
      r_stage[1] <= w_issue;
      for (int k = 2; k <= LATENCY; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
      if (w_dGnt | w_iGnt) begin
        r_lastAddr <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized and directed traffic against a behavioural arbiter/memory model.
// Expected responses are queued per owner at grant time and popped by an independent monitor.
module tb_memory_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_ext = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, mem_ext, mem_exc;
  logic [1:0]  mem_size;

  memory_arbiter #(.LATENCY(LAT), .ADDRESS_SIZE(32), .WORD(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size), .d_ext(d_ext),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_size(mem_size), .mem_ext(mem_ext), .mem_rdata(mem_rdata), .mem_exc(mem_exc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                         input logic [1:0] size, input logic zext);
    logic [31:0] s;
    s = w >> (8 * off);
    if (size == 2'd0) return zext ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    if (size == 2'd1) return zext ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                        input logic [1:0] size, input logic [31:0] d);
    logic [31:0] m;
    m = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    m = m << (8 * off);
    return (w & ~m) | ((d << (8 * off)) & m);
  endfunction

  // Memory_Interface stand-in: captures at issue, extends with mem_ext on the return cycle,
  // and raises mem_exc for stores into the 0x1000 region (which are not written).
  typedef struct packed {
    logic [31:0] raw;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        exc;
  } mp_t;

  mp_t         memPipe [1:LAT];
  logic [31:0] envMem  [0:63];

  always @(posedge clk) begin
    for (int k = LAT; k > 1; k--) memPipe[k] = memPipe[k-1];
    memPipe[1] = '0;
    if (mem_en) begin
      if (mem_we) begin
        if (mem_addr[12]) memPipe[1].exc = 1'b1;
        else envMem[mem_addr[7:2]] = merge(envMem[mem_addr[7:2]], mem_addr[1:0], mem_size, mem_wdata);
      end else begin
        memPipe[1].raw  = envMem[mem_addr[7:2]];
        memPipe[1].off  = mem_addr[1:0];
        memPipe[1].size = mem_size;
      end
    end
  end

  assign mem_rdata = extend(memPipe[LAT].raw, memPipe[LAT].off, memPipe[LAT].size, mem_ext);
  assign mem_exc   = memPipe[LAT].exc;

  // Reference model state.
  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic [31:0] refMem [0:63];
  bit          readAt [int];
  bit          prioD = 1'b1;
  bit          expDGnt = 1'b0, expIGnt = 1'b0;
  exp_t        qI[$], qD[$];

  task automatic checkOutput();
    bit   hz, dEl, mis;
    exp_t e;
    hz  = readAt.exists(cyc - LAT);
    dEl = d_req && !(d_we && hz);
`ifdef ARB_ROUND_ROBIN_EN
    if (dEl && i_req) begin
      expDGnt = prioD;
      prioD   = !prioD;
    end else begin
      expDGnt = dEl;
    end
`else
    expDGnt = dEl;
`endif
    expIGnt = i_req && !expDGnt;
    check("d_gnt", {31'b0, d_gnt}, {31'b0, expDGnt});
    check("i_gnt", {31'b0, i_gnt}, {31'b0, expIGnt});
    e.due = cyc + LAT;
    if (expDGnt) begin
      mis = (d_size == 2'd2 && d_addr[1:0] != 2'b00) || (d_size == 2'd1 && d_addr[0]);
      check("mem_en_d", {31'b0, mem_en}, {31'b0, !mis});
      check("mem_we_d", {31'b0, mem_we}, {31'b0, d_we && !mis});
      check("mem_addr_d", mem_addr, d_addr);
      if (d_we) begin
        e.data = '0;
        e.err  = mis || d_addr[12];
        if (!mis && !d_addr[12]) refMem[d_addr[7:2]] = merge(refMem[d_addr[7:2]], d_addr[1:0], d_size, d_wdata);
      end else begin
        e.data = mis ? 32'h0 : extend(refMem[d_addr[7:2]], d_addr[1:0], d_size, d_ext);
        e.err  = mis;
        readAt[cyc] = 1'b1;
      end
      qD.push_back(e);
    end else if (expIGnt) begin
      mis = (i_addr[1:0] != 2'b00);
      check("mem_en_i", {31'b0, mem_en}, {31'b0, !mis});
      check("mem_we_i", {31'b0, mem_we}, 32'h0);
      e.data = mis ? 32'h0 : refMem[i_addr[7:2]];
      e.err  = mis;
      readAt[cyc] = 1'b1;
      qI.push_back(e);
    end else begin
      check("mem_en_idle", {30'b0, mem_en, mem_we}, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (i_rvalid) begin
        if (qI.size() == 0) check("i_extra_rvalid", 32'h1, 32'h0);
        else begin
          e = qI.pop_front();
          check("i_resp_cycle", cyc, e.due);
          check("i_rdata", i_rdata, e.data);
          check("i_err", {31'b0, i_err}, {31'b0, e.err});
        end
      end else if (qI.size() > 0 && qI[0].due <= cyc) begin
        e = qI.pop_front();
        check("i_missing_rvalid", 32'h0, 32'h1);
      end
      if (d_rvalid) begin
        if (qD.size() == 0) check("d_extra_rvalid", 32'h1, 32'h0);
        else begin
          e = qD.pop_front();
          check("d_resp_cycle", cyc, e.due);
          check("d_rdata", d_rdata, e.data);
          check("d_err", {31'b0, d_err}, {31'b0, e.err});
        end
      end else if (qD.size() > 0 && qD[0].due <= cyc) begin
        e = qD.pop_front();
        check("d_missing_rvalid", 32'h0, 32'h1);
      end
    end
  end

  task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                               input logic [31:0] da, input logic [31:0] dd,
                               input logic [1:0] ds, input bit de);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_size = ds; d_ext = de;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  // Requests are held high during reset to confirm nothing leaks through.
  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_size = 2'd2; d_ext = 1'b1;
    qI.delete(); qD.delete(); readAt.delete();
    prioD = 1'b1; expDGnt = 1'b0; expIGnt = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_ctrl", {22'b0, i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid, i_err, d_err, mem_ext, mem_size}, 32'h0);
      check("reset_mem_addr", mem_addr, 32'h0);
      check("reset_rdata", i_rdata | d_rdata | mem_wdata, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  function automatic logic [31:0] randAddr(input logic [1:0] size);
    logic [31:0] a;
    a = $urandom_range(0, 255);
    if (($urandom % 5) != 0) a = a & ~((32'h1 << size) - 32'h1);
    if (($urandom % 10) == 0) a = a | 32'h1000;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          hI, hD, dw, de;
    logic [31:0] ia, da, dd;
    logic [1:0]  ds;
    for (int k = 1; k <= LAT; k++) memPipe[k] = '0;
    for (int i = 0; i < 64; i++) begin
      envMem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      refMem[i] = envMem[i];
    end
    envMem[4] = 32'hDEAD_BEEF;
    refMem[4] = 32'hDEAD_BEEF;

    doReset();

    // Fetch of a known word, then byte store/load with both extension modes.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    idle(3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 32'h80, 2'd0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1);
    idle(3);

    // Contention for three cycles, then fetch alone.
    for (int n = 0; n < 3; n++)
      applyStimulus(1'b1, 32'h18, 1'b1, 1'b0, 32'h30 + 4 * n, 32'h0, 2'd2, 1'b0);
    applyStimulus(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    idle(3);

    // Store arriving while a load returns is held off one cycle.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
    idle(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 2'd2, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 2'd2, 1'b0);
    idle(3);

    // Misaligned half store, then read back the untouched word.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h01, 32'hFFFF, 2'd1, 1'b0);
    idle(2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h00, 32'h0, 2'd2, 1'b0);
    idle(3);

    // Reset with two loads in flight, then a fresh load.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 2'd2, 1'b0);
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    idle(3);

    hI = 1'b0; hD = 1'b0; dw = 1'b0; de = 1'b0; ia = '0; da = '0; dd = '0; ds = '0;
    for (int n = 0; n < 600; n++) begin
      if (!hI || expIGnt) begin
        hI = (($urandom % 3) != 0);
        ia = randAddr(2'd2);
      end
      if (!hD || expDGnt) begin
        hD = (($urandom % 2) != 0);
        dw = (($urandom % 2) != 0);
        ds = 2'($urandom_range(0, 2));
        da = randAddr(ds);
        dd = $urandom;
        de = (($urandom % 2) != 0);
      end
      applyStimulus(hI, ia, hD, dw, da, dd, ds, de);
      if (n == 300) begin
        doReset();
        hI = 1'b0;
        hD = 1'b0;
      end
    end

    idle(LAT + 2);
    check("queues_drained", qI.size() + qD.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
